// File: rtl/pht_access_scheduler.sv
// pht_access_scheduler: owns the single-port gshare PHT, runs the clear sweep,
// queues commit updates and applies them as RMW. Option: PHT_TAG_MISS_REINIT_EN.
module pht_access_scheduler #(
    parameter int INDEX_WIDTH  = 10,
    parameter int TAG_WIDTH    = 8,
    parameter int QUEUE_DEPTH  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   query_valid_i,
    input  logic [INDEX_WIDTH-1:0] query_index_i,
    output logic                   query_grant_o,
    input  logic                   update_valid_i,
    input  logic [INDEX_WIDTH-1:0] update_index_i,
    input  logic [TAG_WIDTH-1:0]   update_tag_i,
    input  logic                   update_taken_i,
    output logic                   update_ready_o,
    output logic                   pht_en_o,
    output logic                   pht_we_o,
    output logic [INDEX_WIDTH-1:0] pht_addr_o,
    output logic [TAG_WIDTH+2:0]   pht_wdata_o,
    input  logic [TAG_WIDTH+2:0]   pht_rdata_i,
    output logic                   init_busy_o
);

    localparam int EW = TAG_WIDTH + 3;
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD_RD, S_UPD_WR} state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] ptr_q;
    logic [INDEX_WIDTH-1:0] q_index [QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0]   q_tag   [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_taken;
    logic [PW-1:0]          head_q, tail_q;
    logic [CW-1:0]          count_q;
    logic [SW-1:0]          starve_q;
    logic [INDEX_WIDTH-1:0] cur_index_q;
    logic [TAG_WIDTH-1:0]   cur_tag_q;
    logic                   cur_taken_q;
    logic [EW-1:0]          rd_q;

    logic          full, nonempty, forced, enq, deq;
    logic [2:0]    old_ctr, sat_ctr, new_ctr;
    logic [TAG_WIDTH-1:0] old_tag;
    logic          tag_hit;
    logic [EW-1:0] new_entry;

    assign full     = (count_q == CW'(QUEUE_DEPTH));
    assign nonempty = (count_q != '0);
    assign forced   = full | (nonempty & (starve_q == SW'(STARVE_LIMIT)));
    assign update_ready_o = ~rst & ~full & (state_q != S_INIT);
    assign enq      = update_valid_i & update_ready_o;

    assign old_ctr = rd_q[EW-1 -: 3];
    assign old_tag = rd_q[TAG_WIDTH-1:0];
    assign tag_hit = (old_tag == cur_tag_q);

    // Saturating 3-bit counter step toward the resolved direction
    always_comb begin
        sat_ctr = old_ctr;
        if (cur_taken_q) begin
            if (old_ctr != 3'b111) sat_ctr = old_ctr + 3'd1;
        end else if (old_ctr != 3'b000) begin
            sat_ctr = old_ctr - 3'd1;
        end
    end

    // New entry: counter policy on tag miss depends on build option
    always_comb begin
`ifdef PHT_TAG_MISS_REINIT_EN
        new_ctr = tag_hit ? sat_ctr : (cur_taken_q ? 3'b100 : 3'b011);
`else
        new_ctr = sat_ctr;
`endif
        new_entry = {new_ctr, (tag_hit ? old_tag : cur_tag_q)};
    end

    // Port arbitration, SRAM command and next state
    always_comb begin
        state_d       = state_q;
        pht_en_o      = 1'b0;
        pht_we_o      = 1'b0;
        pht_addr_o    = '0;
        pht_wdata_o   = '0;
        query_grant_o = 1'b0;
        init_busy_o   = 1'b0;
        deq           = 1'b0;
        if (rst) begin
            init_busy_o = 1'b1;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    init_busy_o = 1'b1;
                    pht_en_o    = 1'b1;
                    pht_we_o    = 1'b1;
                    pht_addr_o  = ptr_q;
                    pht_wdata_o = {3'b100, {TAG_WIDTH{1'b0}}};
                    if (ptr_q == '1) state_d = S_IDLE;
                end
                S_IDLE: begin
                    if (forced || (!query_valid_i && nonempty)) begin
                        deq        = 1'b1;
                        pht_en_o   = 1'b1;
                        pht_addr_o = q_index[head_q];
                        state_d    = S_UPD_RD;
                    end else if (query_valid_i) begin
                        query_grant_o = 1'b1;
                        pht_en_o      = 1'b1;
                        pht_addr_o    = query_index_i;
                    end
                end
                S_UPD_RD: state_d = S_UPD_WR;
                S_UPD_WR: begin
                    pht_en_o    = 1'b1;
                    pht_we_o    = 1'b1;
                    pht_addr_o  = cur_index_q;
                    pht_wdata_o = new_entry;
                    state_d     = S_IDLE;
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    // State register and clear-sweep pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT) ptr_q <= ptr_q + 1'b1;
        end
    end

    // Queue pointers, occupancy and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            if (enq) tail_q <= tail_q + 1'b1;
            if (deq) head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(enq) - CW'(deq);
            if (deq) begin
                starve_q <= '0;
            end else if (query_grant_o && nonempty &&
                         starve_q != SW'(STARVE_LIMIT)) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

    // Queue storage, in-flight update and captured read data
    always_ff @(posedge clk) begin
        if (enq) begin
            q_index[tail_q] <= update_index_i;
            q_tag[tail_q]   <= update_tag_i;
            q_taken[tail_q] <= update_taken_i;
        end
        if (deq) begin
            cur_index_q <= q_index[head_q];
            cur_tag_q   <= q_tag[head_q];
            cur_taken_q <= q_taken[head_q];
        end
        if (state_q == S_UPD_RD) rd_q <= pht_rdata_i;
    end

endmodule

// File: tb/tb_pht_access_scheduler.sv
// Directed bench for pht_access_scheduler (INDEX_WIDTH=4, 16-entry PHT model).
// Honours PHT_TAG_MISS_REINIT_EN when computing tag-miss expectations.
module tb_pht_access_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        qv, grant, uv, uk, ready, en, we, busy;
    logic [3:0]  qi, ui, addr;
    logic [7:0]  ut;
    logic [10:0] wdata, rdata;
    int checks = 0;
    int failures = 0;

    logic        poke_en = 1'b0;
    logic [3:0]  poke_addr;
    logic [10:0] poke_data;
    logic [10:0] mem [16];
    logic [14:0] wlog [$];

    pht_access_scheduler #(
        .INDEX_WIDTH(4), .TAG_WIDTH(8), .QUEUE_DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .query_valid_i(qv), .query_index_i(qi), .query_grant_o(grant),
        .update_valid_i(uv), .update_index_i(ui), .update_tag_i(ut),
        .update_taken_i(uk), .update_ready_o(ready),
        .pht_en_o(en), .pht_we_o(we), .pht_addr_o(addr),
        .pht_wdata_o(wdata), .pht_rdata_i(rdata), .init_busy_o(busy)
    );

    always #5 clk = ~clk;

    // Single-port SRAM model with 1-cycle read latency and write log
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        if (en && we) mem[addr] <= wdata;
        if (en && !we) rdata <= mem[addr];
        if (en && we && !busy) wlog.push_back({addr, wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [3:0] a, input logic [10:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        nxt();
        poke_en   = 1'b0;
    endtask

    task automatic init_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk({tag, "_wr"}, {en, we, addr, wdata}, {2'b11, 4'(i), 11'h400});
            chk({tag, "_flags"}, {busy, grant, ready}, 3'b100);
            if (i == 15) begin
                uv = 1'b0;
                qv = 1'b0;
            end
            nxt();
        end
        #1;
        chk({tag, "_done"}, {busy, ready, en}, 3'b010);
    endtask

    task automatic run_update(input string tag, input logic [3:0] idx,
                              input logic [7:0] tg, input logic tk,
                              input logic [10:0] exp);
        uv = 1'b1; ui = idx; ut = tg; uk = tk;
        #1;
        chk({tag, "_accept"}, {ready, en}, 2'b10);
        nxt();
        uv = 1'b0;
        #1;
        chk({tag, "_rd"}, {en, we, addr}, {2'b10, idx});
        nxt();
        #1;
        chk({tag, "_wait"}, {en, grant}, 2'b00);
        nxt();
        #1;
        chk({tag, "_wr"}, {en, we, addr, wdata}, {2'b11, idx, exp});
        nxt();
    endtask

    logic [3:0]  t5_idx [5] = '{4'd10, 4'd11, 4'd12, 4'd10, 4'd13};
    logic [10:0] t5_exp [5] = '{11'h500, 11'h500, 11'h500, 11'h600, 11'h500};
    logic [10:0] exp4;

    initial begin
        rst = 1'b1; qv = 1'b1; qi = 4'd0;
        uv = 1'b1; ui = 4'd0; ut = 8'd0; uk = 1'b0;
        #1;
        chk("rst_out", {en, we, grant, ready, busy}, 5'b00001);
        nxt();
        rst = 1'b0;
        init_sweep("init1");

        poke(4'd7, 11'h705);
        poke(4'd9, 11'h203);

        // Starvation: queries every cycle, one update queued
        qv = 1'b1; qi = 4'd3;
        uv = 1'b1; ui = 4'd7; ut = 8'd5; uk = 1'b1;
        #1;
        chk("t2_first", {grant, ready}, 2'b11);
        nxt();
        uv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t2_grant", {grant, en, we, addr}, {3'b110, 4'd3});
            nxt();
        end
        #1;
        chk("t2_rd_issue", {grant, en, we, addr}, {3'b010, 4'd7});
        nxt();
        #1;
        chk("t2_upd_rd", {grant, en}, 2'b00);
        nxt();
        #1;
        chk("t2_upd_wr", {grant, en, we, addr, wdata},
            {3'b011, 4'd7, 11'h705});
        nxt();
        #1;
        chk("t2_resume", {grant, addr}, {1'b1, 4'd3});
        nxt();
        qv = 1'b0;

        run_update("t3_nt", 4'd7, 8'd5, 1'b0, 11'h605);
`ifdef PHT_TAG_MISS_REINIT_EN
        exp4 = 11'h309;
`else
        exp4 = 11'h109;
`endif
        run_update("t4_miss", 4'd9, 8'd9, 1'b0, exp4);

        // Queue fill while queries hold the port
        wlog.delete();
        qv = 1'b1; qi = 4'd0; uv = 1'b1; ut = 8'd0; uk = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ui = t5_idx[k];
            #1;
            chk("t5_accept", {ready, grant}, 2'b11);
            nxt();
        end
        ui = t5_idx[4];
        #1;
        chk("t5_full", {ready, grant, en, we, addr}, {4'b0010, 4'd10});
        nxt();
        #1;
        chk("t5_fifth", ready, 1'b1);
        nxt();
        uv = 1'b0; qv = 1'b0;
        for (int c = 0; c < 60 && wlog.size() < 5; c++) nxt();
        chk("t5_nwrites", wlog.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < wlog.size())
                chk("t5_order", wlog[k], {t5_idx[k], t5_exp[k]});
        end

        // Reset while an update is in UPD_RD
        nxt();
        wlog.delete();
        uv = 1'b1; ui = 4'd5; ut = 8'd0; uk = 1'b1;
        #1;
        chk("t6_accept", ready, 1'b1);
        nxt();
        ui = 4'd6;
        #1;
        chk("t6_rd_issue", {en, we, addr}, {2'b10, 4'd5});
        nxt();
        uv = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_out", {en, we, grant, ready, busy}, 5'b00001);
        nxt();
        rst = 1'b0;
        init_sweep("init2");
        nxt();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t6_empty", {en, ready}, 2'b01);
            nxt();
        end
        chk("t6_no_write", wlog.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
